// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters (CPU = m0, loader = m1), the arbiter and the memory.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
// Carries no state; widths follow ADDR_W / DATA_W.
interface mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   // requester 0 (CPU)
   logic              m0_req;
   logic              m0_we;
   logic [ADDR_W-1:0] m0_addr;
   logic [DATA_W-1:0] m0_wdata;
   logic              m0_gnt;
   logic              m0_rvalid;
   // requester 1 (loader)
   logic              m1_req;
   logic              m1_we;
   logic [ADDR_W-1:0] m1_addr;
   logic [DATA_W-1:0] m1_wdata;
   logic              m1_gnt;
   logic              m1_rvalid;
   // shared response, valid with mN_rvalid
   logic              rsp_err;
   logic [DATA_W-1:0] rsp_rdata;
   // memory side
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ready;
   logic              mem_rvalid;
   logic [DATA_W-1:0] mem_rdata;
   // status
   logic              busy;

   modport slave (
      input  m0_req, m0_we, m0_addr, m0_wdata,
      input  m1_req, m1_we, m1_addr, m1_wdata,
      input  mem_ready, mem_rvalid, mem_rdata,
      output m0_gnt, m0_rvalid, m1_gnt, m1_rvalid,
      output rsp_err, rsp_rdata,
      output mem_req, mem_we, mem_addr, mem_wdata,
      output busy
   );

   modport master (
      output m0_req, m0_we, m0_addr, m0_wdata,
      output m1_req, m1_we, m1_addr, m1_wdata,
      output mem_ready, mem_rvalid, mem_rdata,
      input  m0_gnt, m0_rvalid, m1_gnt, m1_rvalid,
      input  rsp_err, rsp_rdata,
      input  mem_req, mem_we, mem_addr, mem_wdata,
      input  busy
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester round-robin memory arbiter, one transaction outstanding (IDLE/ISSUE/WAIT).
// Latency: req -> gnt/mem_req 1 cycle; write done 1 cycle after mem_ready; read done 1 cycle after mem_rvalid.
// Backpressure: ISSUE holds while mem_ready=0; WAIT gives up after TIMEOUT cycles with rsp_err=1.
module mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic          clk_i,
   input  logic          reset_ni,
   mem_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t            state_q, state_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              owner_q, owner_d;
   logic              last_gnt_q, last_gnt_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [1:0]        gnt_q, gnt_d;
   logic [1:0]        rvalid_q, rvalid_d;
   logic              rsp_err_q, rsp_err_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic              win;
   logic              mem_req_s;

   // Next-state: arbitration in IDLE, memory handshake in ISSUE, response/timeout in WAIT.
   always_comb begin
      state_d     = state_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      owner_d     = owner_q;
      last_gnt_d  = last_gnt_q;
      cnt_d       = cnt_q;
      gnt_d       = 2'b00;
      rvalid_d    = 2'b00;
      rsp_err_d   = rsp_err_q;
      rsp_rdata_d = rsp_rdata_q;
      win         = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.m0_req || bus.m1_req) begin
               // on contention the requester that did not win last time goes first
               win        = (bus.m0_req && bus.m1_req) ? ~last_gnt_q : bus.m1_req;
               we_d       = win ? bus.m1_we    : bus.m0_we;
               addr_d     = win ? bus.m1_addr  : bus.m0_addr;
               wdata_d    = win ? bus.m1_wdata : bus.m0_wdata;
               owner_d    = win;
               last_gnt_d = win;
               gnt_d      = win ? 2'b10 : 2'b01;
               state_d    = ISSUE;
            end
         end
         ISSUE: begin
            if (bus.mem_ready) begin
               if (we_q) begin
                  rvalid_d    = owner_q ? 2'b10 : 2'b01;
                  rsp_err_d   = 1'b0;
                  rsp_rdata_d = '0;
                  state_d     = IDLE;
               end else begin
                  cnt_d   = 8'd0;
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            // a response arriving in the last allowed cycle still wins over the timeout
            if (bus.mem_rvalid) begin
               rvalid_d    = owner_q ? 2'b10 : 2'b01;
               rsp_err_d   = 1'b0;
               rsp_rdata_d = bus.mem_rdata;
               state_d     = IDLE;
            end else begin
               cnt_d = cnt_q + 8'd1;
               if (cnt_q == CNT_LAST) begin
                  rvalid_d    = owner_q ? 2'b10 : 2'b01;
                  rsp_err_d   = 1'b1;
                  rsp_rdata_d = '0;
                  state_d     = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and registered outputs; reset aborts any transaction and favours m0 next.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q     <= IDLE;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         owner_q     <= 1'b0;
         last_gnt_q  <= 1'b1;
         cnt_q       <= 8'd0;
         gnt_q       <= 2'b00;
         rvalid_q    <= 2'b00;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         owner_q     <= owner_d;
         last_gnt_q  <= last_gnt_d;
         cnt_q       <= cnt_d;
         gnt_q       <= gnt_d;
         rvalid_q    <= rvalid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   // Memory side is decoded from state so the request appears in the first ISSUE cycle.
   assign mem_req_s     = (state_q == ISSUE);
   assign bus.mem_req   = mem_req_s;
   assign bus.mem_we    = mem_req_s & we_q;
   assign bus.mem_addr  = mem_req_s ? addr_q  : '0;
   assign bus.mem_wdata = mem_req_s ? wdata_q : '0;
   assign bus.busy      = (state_q != IDLE);

   assign bus.m0_gnt    = gnt_q[0];
   assign bus.m1_gnt    = gnt_q[1];
   assign bus.m0_rvalid = rvalid_q[0];
   assign bus.m1_rvalid = rvalid_q[1];
   assign bus.rsp_err   = rsp_err_q;
   assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, read, round-robin, wait states, timeout, reset abort.
// Completions are checked by a monitor against a queue of expected responses.
// Inputs change 1 time unit after the rising edge; outputs are checked then or on the falling edge.
module tb_mem_arbiter;

   logic clk;
   logic reset_ni;
   int   n_cmp = 0;
   int   n_err = 0;

   typedef struct {
      logic        own;
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   exp_t sb[$];

   mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
      .clk_i    (clk),
      .reset_ni (reset_ni),
      .bus      (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic own, input logic err, input logic [31:0] rd);
      exp_t e;
      e.own   = own;
      e.err   = err;
      e.rdata = rd;
      sb.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // every completion pulse must match the oldest expected response
   always @(negedge clk) begin
      if (bus.m0_rvalid === 1'b1 || bus.m1_rvalid === 1'b1) begin
         chk("rv_expected", sb.size() != 0, 1'b1);
         if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("rv_owner", {bus.m1_rvalid, bus.m0_rvalid}, e.own ? 2'b10 : 2'b01);
            chk("rv_err", bus.rsp_err, e.err);
            chk("rv_rdata", bus.rsp_rdata, e.rdata);
         end
      end
   end

   initial begin
      reset_ni       = 1'b1;
      bus.m0_req     = 1'b0;
      bus.m0_we      = 1'b0;
      bus.m0_addr    = '0;
      bus.m0_wdata   = '0;
      bus.m1_req     = 1'b0;
      bus.m1_we      = 1'b0;
      bus.m1_addr    = '0;
      bus.m1_wdata   = '0;
      bus.mem_ready  = 1'b0;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = '0;

      // reset state
      #1 reset_ni = 1'b0;
      #2;
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_mem_req", bus.mem_req, 1'b0);
      chk("rst_gnt", {bus.m1_gnt, bus.m0_gnt}, 2'b00);
      chk("rst_rvalid", {bus.m1_rvalid, bus.m0_rvalid}, 2'b00);
      chk("rst_rdata", bus.rsp_rdata, 32'h0);
      tick();
      tick();
      reset_ni = 1'b1;

      // m0 read of 0x100, memory ready at once, data the next cycle
      bus.m0_req  = 1'b1;
      bus.m0_we   = 1'b0;
      bus.m0_addr = 32'h100;
      push(1'b0, 1'b0, 32'hCAFEF00D);
      tick();
      chk("rd_gnt0", bus.m0_gnt, 1'b1);
      chk("rd_gnt1", bus.m1_gnt, 1'b0);
      chk("rd_mem_req", bus.mem_req, 1'b1);
      chk("rd_mem_addr", bus.mem_addr, 32'h100);
      chk("rd_mem_we", bus.mem_we, 1'b0);
      chk("rd_busy", bus.busy, 1'b1);
      bus.m0_req    = 1'b0;
      bus.mem_ready = 1'b1;
      tick();
      chk("rd_wait_mem_req", bus.mem_req, 1'b0);
      chk("rd_wait_addr0", bus.mem_addr, 32'h0);
      chk("rd_wait_gnt0", bus.m0_gnt, 1'b0);
      bus.mem_ready  = 1'b0;
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'hCAFEF00D;
      tick();
      chk("rd_rvalid_cyc3", bus.m0_rvalid, 1'b1);
      chk("rd_rdata", bus.rsp_rdata, 32'hCAFEF00D);
      chk("rd_done_busy", bus.busy, 1'b0);
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = '0;

      // m1 write to 0x40 with three wait states
      bus.m1_req   = 1'b1;
      bus.m1_we    = 1'b1;
      bus.m1_addr  = 32'h40;
      bus.m1_wdata = 32'h12345678;
      push(1'b1, 1'b0, 32'h0);
      tick();
      bus.m1_req  = 1'b0;
      bus.m1_addr = 32'hFFF;
      for (int k = 0; k < 4; k++) begin
         chk("ws_gnt1", bus.m1_gnt, k == 0);
         chk("ws_mem_req", bus.mem_req, 1'b1);
         chk("ws_mem_addr", bus.mem_addr, 32'h40);
         chk("ws_mem_we", bus.mem_we, 1'b1);
         chk("ws_mem_wdata", bus.mem_wdata, 32'h12345678);
         chk("ws_no_rvalid", bus.m1_rvalid, 1'b0);
         if (k == 3) bus.mem_ready = 1'b1;
         tick();
      end
      chk("ws_rvalid1", bus.m1_rvalid, 1'b1);
      chk("ws_mem_req_off", bus.mem_req, 1'b0);
      bus.mem_ready = 1'b0;

      // both requesters continuously: grants alternate m0, m1, m0, m1
      bus.m0_req   = 1'b1;
      bus.m0_we    = 1'b1;
      bus.m0_addr  = 32'h10;
      bus.m0_wdata = 32'hA0A00000;
      bus.m1_req   = 1'b1;
      bus.m1_we    = 1'b1;
      bus.m1_addr  = 32'h20;
      bus.m1_wdata = 32'hB1B10000;
      bus.mem_ready = 1'b1;
      for (int i = 0; i < 4; i++) push((i % 2) == 1, 1'b0, 32'h0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("rr_gnt0", bus.m0_gnt, (i % 2) == 0);
         chk("rr_gnt1", bus.m1_gnt, (i % 2) == 1);
         chk("rr_mem_addr", bus.mem_addr, ((i % 2) == 1) ? 32'h20 : 32'h10);
         if (i == 3) begin
            bus.m0_req = 1'b0;
            bus.m1_req = 1'b0;
         end
         tick();
      end
      bus.mem_ready = 1'b0;
      tick();
      chk("rr_idle_busy", bus.busy, 1'b0);

      // m0 read that times out; mem_rvalid during ISSUE must be ignored
      bus.m0_req  = 1'b1;
      bus.m0_we   = 1'b0;
      bus.m0_addr = 32'h200;
      push(1'b0, 1'b1, 32'h0);
      tick();
      chk("to_gnt0", bus.m0_gnt, 1'b1);
      bus.m0_req     = 1'b0;
      bus.mem_ready  = 1'b1;
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'hDEAD;
      tick();
      bus.mem_ready  = 1'b0;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = '0;
      for (int k = 0; k < 4; k++) begin
         chk("to_wait_rvalid", bus.m0_rvalid, 1'b0);
         chk("to_wait_busy", bus.busy, 1'b1);
         tick();
      end
      chk("to_rvalid", bus.m0_rvalid, 1'b1);
      chk("to_err", bus.rsp_err, 1'b1);
      chk("to_rdata", bus.rsp_rdata, 32'h0);

      // m0 read answered in the last WAIT cycle: normal response wins
      bus.m0_req  = 1'b1;
      bus.m0_addr = 32'h204;
      push(1'b0, 1'b0, 32'h0BADBEEF);
      tick();
      bus.m0_req    = 1'b0;
      bus.mem_ready = 1'b1;
      tick();
      bus.mem_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk("late_wait_rvalid", bus.m0_rvalid, 1'b0);
         if (k == 3) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = 32'h0BADBEEF;
         end
         tick();
      end
      bus.mem_rvalid = 1'b0;
      chk("late_rvalid", bus.m0_rvalid, 1'b1);
      chk("late_err", bus.rsp_err, 1'b0);

      // stray mem_rvalid in IDLE is ignored
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'h5555;
      tick();
      bus.mem_rvalid = 1'b0;
      chk("idle_rv_busy", bus.busy, 1'b0);

      // reset pulse in WAIT aborts; m0 wins the next simultaneous request
      bus.m0_req  = 1'b1;
      bus.m0_addr = 32'h300;
      tick();
      bus.m0_req    = 1'b0;
      bus.mem_ready = 1'b1;
      tick();
      bus.mem_ready = 1'b0;
      chk("ra_wait_busy", bus.busy, 1'b1);
      tick();
      reset_ni = 1'b0;
      #1;
      chk("ra_busy", bus.busy, 1'b0);
      chk("ra_mem_req", bus.mem_req, 1'b0);
      chk("ra_mem_addr", bus.mem_addr, 32'h0);
      chk("ra_gnt", {bus.m1_gnt, bus.m0_gnt}, 2'b00);
      chk("ra_rvalid", {bus.m1_rvalid, bus.m0_rvalid}, 2'b00);
      chk("ra_err", bus.rsp_err, 1'b0);
      chk("ra_rdata", bus.rsp_rdata, 32'h0);
      tick();
      reset_ni       = 1'b1;
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'h7777;
      tick();
      bus.mem_rvalid = 1'b0;
      chk("ra_late_busy", bus.busy, 1'b0);
      chk("ra_late_rvalid", bus.m0_rvalid, 1'b0);
      bus.m0_req   = 1'b1;
      bus.m0_we    = 1'b1;
      bus.m0_addr  = 32'h50;
      bus.m1_req   = 1'b1;
      bus.m1_we    = 1'b1;
      bus.m1_addr  = 32'h60;
      bus.mem_ready = 1'b1;
      push(1'b0, 1'b0, 32'h0);
      tick();
      chk("ra_first_gnt0", bus.m0_gnt, 1'b1);
      chk("ra_first_gnt1", bus.m1_gnt, 1'b0);
      chk("ra_first_addr", bus.mem_addr, 32'h50);
      bus.m0_req = 1'b0;
      bus.m1_req = 1'b0;
      tick();
      chk("ra_first_rvalid", bus.m0_rvalid, 1'b1);
      bus.mem_ready = 1'b0;
      tick();
      tick();

      chk("sb_empty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
